hazard_sb: RTL



---
 rtl/hazard_pkg.sv | 15 +
 rtl/hazard_scoreboard.sv | 60 ++++++
 rtl/hazard_sb.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and default sizing for the hazard / scoreboard unit.
// Optional perf counters in hazard_sb are enabled with HAZARD_PERF_CNT_EN.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    localparam int NREG_DEF   = 32;
    localparam int NSRC_DEF   = 2;
    localparam int MAX_LU_DEF = 4;

endpackage

// File: rtl/hazard_scoreboard.sv
// Busy-register scoreboard for long-latency ops: tracks destinations issued from E
// until their out-of-order completion, with an outstanding count and sticky error.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREG   = NREG_DEF,
    parameter int MAX_LU = MAX_LU_DEF,
    parameter int AW     = $clog2(NREG),
    parameter int CW     = $clog2(MAX_LU + 1) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            issue,
    input  logic [AW-1:0]   issue_rd,
    input  logic            done,
    input  logic [AW-1:0]   done_rd,
    output logic [NREG-1:0] busy,
    output logic [CW-1:0]   count,
    output logic            err
);

    logic [NREG-1:0] busy_q, busy_d;
    logic [CW-1:0]   count_q, count_d;
    logic            err_q, err_d;
    logic            done_ok;

    // A completion is legal only when something is outstanding and its register is busy.
    always_comb begin
        done_ok = done && (count_q != '0) && busy_q[done_rd];
        busy_d  = busy_q;
        count_d = count_q;
        err_d   = err_q;
        if (done_ok) busy_d[done_rd] = 1'b0;
        if (issue)   busy_d[issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
        if (done && !done_ok) err_d = 1'b1;
        case ({issue, done_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign busy  = busy_q;
    assign count = count_q;
    assign err   = err_q;

endmodule

// File: rtl/hazard_sb.sv
// Pipeline hazard unit: forwarding, load-use / scoreboard stalls, branch flushes and
// cache-miss freezes. Perf counters exist only when HAZARD_PERF_CNT_EN is defined.
module hazard_sb
    import hazard_pkg::*;
#(
    parameter int NREG   = NREG_DEF,
    parameter int NSRC   = NSRC_DEF,
    parameter int MAX_LU = MAX_LU_DEF,
    parameter int AW     = $clog2(NREG)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NSRC*AW-1:0] rs_d,
    input  logic [NSRC-1:0]    rs_used_d,
    input  logic [AW-1:0]      rd_d,
    input  logic               reg_write_d,
    input  logic               long_d,
    input  logic [NSRC*AW-1:0] rs_e,
    input  logic [AW-1:0]      rd_e,
    input  logic               reg_write_e,
    input  logic               load_e,
    input  logic               long_e,
    input  logic               pc_src_e,
    input  logic [AW-1:0]      rd_m,
    input  logic [AW-1:0]      rd_w,
    input  logic               reg_write_m,
    input  logic               reg_write_w,
    input  logic               mem_stall,
    input  logic               lu_done,
    input  logic [AW-1:0]      lu_rd,
    output logic               stall_f,
    output logic               stall_d,
    output logic               stall_e,
    output logic               stall_m,
    output logic               flush_d,
    output logic               flush_e,
    output logic [2*NSRC-1:0]  fwd_e,
    output logic [NREG-1:0]    sb_busy,
    output logic               sb_err,
    output logic [31:0]        stall_cnt,
    output logic [31:0]        flush_cnt
);

    localparam int CW = $clog2(MAX_LU + 1) + 1;

    logic [CW-1:0] lu_count;
    logic          lu_issue;
    logic          ld_hz, lu_hz, lu_full, hz;

    assign lu_issue = long_e && reg_write_e && (rd_e != '0) && !mem_stall;

    hazard_scoreboard #(
        .NREG   (NREG),
        .MAX_LU (MAX_LU),
        .AW     (AW),
        .CW     (CW)
    ) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .issue    (lu_issue),
        .issue_rd (rd_e),
        .done     (lu_done),
        .done_rd  (lu_rd),
        .busy     (sb_busy),
        .count    (lu_count),
        .err      (sb_err)
    );

    always_comb begin
        ld_hz = 1'b0;
        lu_hz = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (rs_used_d[i] && (rs_d[i*AW +: AW] != '0)) begin
                if (load_e && reg_write_e && (rd_e != '0) && (rd_e == rs_d[i*AW +: AW])) ld_hz = 1'b1;
                if (sb_busy[rs_d[i*AW +: AW]]) lu_hz = 1'b1;
            end
        end
        if (reg_write_d && (rd_d != '0) && sb_busy[rd_d]) lu_hz = 1'b1;
        // The op sitting in E will occupy a slot before D can issue, so count it too.
        lu_full = long_d && ((int'(lu_count) + int'(long_e)) >= MAX_LU);
        hz      = ld_hz || lu_hz || lu_full;
    end

    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        if (mem_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
        end else if (pc_src_e) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (hz) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    always_comb begin
        fwd_e = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (rs_e[i*AW +: AW] != '0) begin
                if (reg_write_m && (rs_e[i*AW +: AW] == rd_m))      fwd_e[2*i +: 2] = FWD_M;
                else if (reg_write_w && (rs_e[i*AW +: AW] == rd_w)) fwd_e[2*i +: 2] = FWD_W;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_d && !mem_stall)  stall_cnt_d = stall_cnt_q + 32'd1;
        if (pc_src_e && !mem_stall) flush_cnt_d = flush_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
